// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: control-state encodings
// (common with the Booth multiplier), default width and divide-by-zero fill.
package div_pkg;

    localparam int unsigned DIV_WIDTH = 64;
    localparam int unsigned DIV_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } div_state_e;

    // Quotient on divide-by-zero is this bit replicated across the word (all ones / -1).
    localparam logic DIV_ZERO_QUOT_BIT = 1'b1;

endpackage

// File: rtl/cla64.sv
// Team carry-lookahead adder; the lookahead tree is left to the synthesis adder library.
module cla64 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);

endmodule

// File: rtl/divider_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference when it does not go negative.
module divider_step #(
    parameter int unsigned WIDTH = 64
) (
    input  logic [WIDTH-1:0] p_cur,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_next,
    output logic             q_bit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             carry_lo;

    assign shifted = {p_cur, q_msb};

    cla64 #(.WIDTH(WIDTH)) u_sub (
        .a    (shifted[WIDTH-1:0]),
        .b    (~d),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry_lo)
    );

    // The shifted value carries one bit above the divisor width; the trial
    // difference is non-negative when that bit is set or the low subtract does not borrow.
    assign q_bit  = shifted[WIDTH] | carry_lo;
    assign p_next = q_bit ? diff : shifted[WIDTH-1:0];

endmodule

// File: rtl/divider_os.sv
// Sequential radix-2 restoring divider with INIT/EXEC/DONE control and op_clear/op_done handshake.
// Define DIVIDER_SIGNED_DIV_EN for two's-complement operands (truncating division).
module divider_os
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             op_done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] p_next;
    logic             q_bit;
    logic [WIDTH-1:0] quot_raw;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_fin;
    logic [WIDTH-1:0] rem_fin;

    divider_step #(.WIDTH(WIDTH)) u_step (
        .p_cur  (p_q),
        .q_msb  (q_q[WIDTH-1]),
        .d      (d_q),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    assign quot_raw = {q_q[WIDTH-2:0], q_bit};

`ifdef DIVIDER_SIGNED_DIV_EN
    logic neg_q;
    logic neg_r;

    // Magnitudes feed the unsigned core; MIN maps onto itself, which is its correct unsigned magnitude.
    assign a_mag    = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    assign b_mag    = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;
    assign quot_fin = neg_q ? (~quot_raw + WIDTH'(1)) : quot_raw;
    assign rem_fin  = neg_r ? (~p_next   + WIDTH'(1)) : p_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (op_clear) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == ST_INIT && op_start) begin
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
        end
    end
`else
    assign a_mag    = dividend;
    assign b_mag    = divisor;
    assign quot_fin = quot_raw;
    assign rem_fin  = p_next;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_INIT;
            cnt         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            op_done     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (op_clear) begin
            state       <= ST_INIT;
            cnt         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            op_done     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (op_start) begin
                        if (divisor == '0) begin
                            state       <= ST_DONE;
                            op_done     <= 1'b1;
                            quotient    <= {WIDTH{DIV_ZERO_QUOT_BIT}};
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= ST_EXEC;
                            cnt   <= '0;
                            p_q   <= '0;
                            q_q   <= a_mag;
                            d_q   <= b_mag;
                        end
                    end
                end
                ST_EXEC: begin
                    p_q <= p_next;
                    q_q <= quot_raw;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state     <= ST_DONE;
                        op_done   <= 1'b1;
                        quotient  <= quot_fin;
                        remainder <= rem_fin;
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    // Unreachable encoding: poison outputs in simulation and recover.
                    state       <= ST_INIT;
                    op_done     <= 1'bx;
                    quotient    <= 'x;
                    remainder   <= 'x;
                    div_by_zero <= 1'bx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_os.sv
// Self-checking bench for divider_os: scoreboard of expected results, directed and random operands.
// Compile with DIVIDER_SIGNED_DIV_EN to exercise the signed build.
module tb_divider_os;

    localparam int unsigned W       = 64;
    localparam int          MAX_LAT = 200;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         op_start = 1'b0;
    logic         op_clear = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         op_done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    divider_os #(.WIDTH(W), .CNT_W(7)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .op_done     (op_done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [W-1:0] min_v;
        min_v = {1'b1, {(W-1){1'b0}}};
        e.dbz = (b == '0);
        e.lat = (b == '0) ? 1 : W + 1;
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef DIVIDER_SIGNED_DIV_EN
            if (a == min_v && b == '1) begin
                e.q = min_v;
                e.r = '0;
            end else begin
                e.q = W'($signed(a) / $signed(b));
                e.r = W'($signed(a) % $signed(b));
            end
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    task automatic check_idle(input string tag);
        check_val({tag, "_done"}, W'(op_done), '0);
        check_val({tag, "_q"}, quotient, '0);
        check_val({tag, "_r"}, remainder, '0);
        check_val({tag, "_dbz"}, W'(div_by_zero), '0);
    endtask

    task automatic do_clear();
        @(negedge clk);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
    endtask

    // Latency counts edges from, and including, the edge that samples op_start.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit disturb);
        exp_t e;
        int   lat;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        op_start = 1'b0;
        lat = 1;
        while (!op_done && lat < MAX_LAT) begin
            if (disturb && lat == 20) begin
                dividend = {$urandom, $urandom};
                divisor  = {$urandom, $urandom};
                op_start = 1'b1;
            end else if (disturb && lat == 21) begin
                op_start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        check_val({tag, "_lat"}, W'(lat), W'(e.lat));
        check_val({tag, "_done"}, W'(op_done), W'(1));
        check_val({tag, "_q"}, quotient, e.q);
        check_val({tag, "_r"}, remainder, e.r);
        check_val({tag, "_dbz"}, W'(div_by_zero), W'(e.dbz));
        if (disturb) begin
            @(negedge clk);
            dividend = 64'd12;
            divisor  = 64'd0;
            op_start = 1'b1;
            repeat (2) @(negedge clk);
            op_start = 1'b0;
            check_val({tag, "_hold_done"}, W'(op_done), W'(1));
            check_val({tag, "_hold_q"}, quotient, e.q);
            check_val({tag, "_hold_r"}, remainder, e.r);
            check_val({tag, "_hold_dbz"}, W'(div_by_zero), W'(e.dbz));
        end
        do_clear();
        check_idle({tag, "_clr"});
    endtask

    initial begin
        logic [W-1:0] min_v;
        min_v = {1'b1, {(W-1){1'b0}}};

        #12;
        check_idle("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("post_reset");

        run_op("d100_7", 64'd100, 64'd7, 1'b0);
        run_op("ones_1", '1, 64'd1, 1'b0);
        run_op("d5_9", 64'd5, 64'd9, 1'b0);
        run_op("d1234_0", 64'd1234, 64'd0, 1'b0);

        // op_clear while cnt==30 discards the in-flight result
        @(negedge clk);
        dividend = 64'd1000;
        divisor  = 64'd3;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        check_idle("midclr");
        repeat (70) @(posedge clk);
        #1;
        check_val("midclr_stay", W'(op_done), '0);
        run_op("d81_9", 64'd81, 64'd9, 1'b0);

        // async reset mid-EXEC and while holding a divide-by-zero result
        @(negedge clk);
        dividend = 64'd500;
        divisor  = 64'd7;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("rst_exec");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        dividend = 64'd77;
        divisor  = 64'd0;
        op_start = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        check_val("rst_done_pre", W'(op_done), W'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("rst_done");
        @(negedge clk);
        reset_n = 1'b1;

        // start and clear together: clear wins, a zero divisor would otherwise finish at once
        @(negedge clk);
        dividend = 64'd5;
        divisor  = 64'd0;
        op_start = 1'b1;
        op_clear = 1'b1;
        @(negedge clk);
        op_start = 1'b0;
        op_clear = 1'b0;
        check_idle("start_clr");

        run_op("disturb", 64'd200, 64'd6, 1'b1);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = {$urandom, $urandom};
            b = (i < 4) ? {$urandom, $urandom} : W'($urandom_range(1, 1000));
            run_op("rand", a, b, 1'b0);
        end

`ifdef DIVIDER_SIGNED_DIV_EN
        run_op("s_m7_2", -64'sd7, 64'sd2, 1'b0);
        run_op("s_7_m2", 64'sd7, -64'sd2, 1'b0);
        run_op("s_min_m1", min_v, '1, 1'b0);
        run_op("s_m7_0", -64'sd7, 64'd0, 1'b0);
`else
        run_op("u_min_3", min_v, 64'd3, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
